// File: rtl/neopixel_rx_if.sv
// neopixel_rx_if: serial line in, decoded pixel stream and frame/error events out.
interface neopixel_rx_if #(
    parameter int NUM_PIXELS = 8
);
    logic                          neopixel_data;
    logic                          pixel_valid;
    logic [$clog2(NUM_PIXELS)-1:0] pixel_index;
    logic [7:0]                    red;
    logic [7:0]                    green;
    logic [7:0]                    blue;
    logic                          frame_done;
    logic                          error;
    logic                          overflow;
    modport master (
        input  neopixel_data,
        output pixel_valid, pixel_index, red, green, blue, frame_done, error, overflow
    );
    modport slave (
        output neopixel_data,
        input  pixel_valid, pixel_index, red, green, blue, frame_done, error, overflow
    );
endinterface

// File: rtl/neopixel_rx.sv
// neopixel_rx: WS2812 serial decoder producing per-pixel GRB bytes plus latch and error events.
module neopixel_rx #(
    parameter int NUM_PIXELS   = 8,
    parameter int MIN_HIGH     = 8,
    parameter int BIT_THRESH   = 30,
    parameter int MAX_HIGH     = 60,
    parameter int LATCH_CYCLES = 2500
) (
    input logic           CLOCK_50,
    input logic           reset,
    neopixel_rx_if.master bus
);
    localparam int IW = $clog2(NUM_PIXELS);
    localparam int PW = $clog2(NUM_PIXELS + 1);
    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam int HW = $clog2(MAX_HIGH + 1);
    localparam logic [LW-1:0] LATCH = LW'(LATCH_CYCLES);
    localparam logic [HW-1:0] MINH  = HW'(MIN_HIGH);
    localparam logic [HW-1:0] THR   = HW'(BIT_THRESH);
    localparam logic [HW-1:0] MAXH  = HW'(MAX_HIGH);
    localparam logic [PW-1:0] NPIX  = PW'(NUM_PIXELS);

    typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

    state_t        state, state_n;
    logic          s0, line, line_d, rise;
    logic [23:0]   sr, sr_n;
    logic [4:0]    bit_cnt, bit_cnt_n;
    logic [PW-1:0] pix_cnt, pix_cnt_n;
    logic [LW-1:0] low_cnt, low_cnt_n, low_inc;
    logic [HW-1:0] high_cnt, high_cnt_n, high_inc;
    logic          word_done, word_done_n, frame_n, err_n, ovf_n;

    assign rise     = line & ~line_d;
    assign low_inc  = low_cnt + LW'(1);
    assign high_inc = high_cnt + HW'(1);

    always_comb begin
        state_n     = state;
        sr_n        = sr;
        bit_cnt_n   = bit_cnt;
        pix_cnt_n   = pix_cnt;
        low_cnt_n   = low_cnt;
        high_cnt_n  = high_cnt;
        word_done_n = 1'b0;
        frame_n     = 1'b0;
        err_n       = 1'b0;
        ovf_n       = bus.overflow;
        case (state)
            SYNC: begin
                low_cnt_n = line ? '0 : low_inc;
                if (!line && low_inc == LATCH) begin
                    state_n   = LOW;
                    pix_cnt_n = '0;
                    ovf_n     = 1'b0;
                end
            end
            LOW: begin
                if (rise) begin
                    high_cnt_n = HW'(1);
                    state_n    = HIGH;
                end else if (low_cnt != LATCH) begin
                    low_cnt_n = low_inc;
                    if (low_inc == LATCH && bit_cnt != 5'd0) begin
                        err_n     = 1'b1;
                        state_n   = SYNC;
                        low_cnt_n = '0;
                        bit_cnt_n = '0;
                    end else if (low_inc == LATCH && pix_cnt != '0) begin
                        frame_n   = 1'b1;
                        pix_cnt_n = '0;
                        ovf_n     = 1'b0;
                    end
                end
            end
            HIGH: begin
                if (line ? high_inc == MAXH : high_cnt < MINH) begin
                    err_n     = 1'b1;
                    state_n   = SYNC;
                    low_cnt_n = '0;
                    bit_cnt_n = '0;
                end else if (line) begin
                    high_cnt_n = high_inc;
                end else begin
                    // the fall cycle is already the first low cycle of the gap
                    sr_n      = {sr[22:0], high_cnt >= THR};
                    low_cnt_n = LW'(1);
                    state_n   = LOW;
                    bit_cnt_n = (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
                    if (bit_cnt == 5'd23 && pix_cnt != NPIX) begin
                        word_done_n = 1'b1;
                        pix_cnt_n   = pix_cnt + PW'(1);
                    end else if (bit_cnt == 5'd23) begin
                        ovf_n = 1'b1;
                    end
                end
            end
            default: state_n = SYNC;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s0              <= 1'b0;
            line            <= 1'b0;
            line_d          <= 1'b0;
            state           <= SYNC;
            sr              <= '0;
            bit_cnt         <= '0;
            pix_cnt         <= '0;
            low_cnt         <= '0;
            high_cnt        <= '0;
            word_done       <= 1'b0;
            bus.pixel_valid <= 1'b0;
            bus.pixel_index <= '0;
            bus.red         <= '0;
            bus.green       <= '0;
            bus.blue        <= '0;
            bus.frame_done  <= 1'b0;
            bus.error       <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            s0              <= bus.neopixel_data;
            line            <= s0;
            line_d          <= line;
            state           <= state_n;
            sr              <= sr_n;
            bit_cnt         <= bit_cnt_n;
            pix_cnt         <= pix_cnt_n;
            low_cnt         <= low_cnt_n;
            high_cnt        <= high_cnt_n;
            word_done       <= word_done_n;
            bus.pixel_valid <= word_done;
            bus.frame_done  <= frame_n;
            bus.error       <= err_n;
            bus.overflow    <= ovf_n;
            if (word_done) begin
                {bus.green, bus.red, bus.blue} <= sr;
                bus.pixel_index                <= IW'(pix_cnt - PW'(1));
            end
        end
    end
endmodule

// File: tb/tb_neopixel_rx.sv
// tb_neopixel_rx: directed WS2812 stimulus checked against a pulse-level protocol model.
module tb_neopixel_rx;
    localparam int NP = 8, LATCH = 2500, MINH = 8, THR = 30, MAXH = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0, fails = 0;

    neopixel_rx_if #(.NUM_PIXELS(NP)) bus ();
    neopixel_rx #(.NUM_PIXELS(NP)) dut (.CLOCK_50(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    bit          synced = 1'b0;
    logic        ovf = 1'b0;
    int          run = 0, bits = 0, pix = 0, exp_fd = 0, exp_err = 0, got_fd = 0, got_err = 0, lat;
    logic [23:0] word = '0;
    logic [26:0] expq[$];
    logic [26:0] e;
    logic [23:0] last_pix[NP];
    logic [7:0]  kb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: a high pulse of h cycles as seen by a receiver that knows only the protocol rules
    task automatic m_high(input int h);
        run = 0;
        if (!synced) return;
        if (h < MINH || h >= MAXH) begin
            exp_err++;
            synced = 1'b0;
            bits   = 0;
            return;
        end
        word = {word[22:0], h >= THR};
        bits++;
        if (bits == 24) begin
            bits = 0;
            if (pix < NP) begin
                expq.push_back({3'(pix), word});
                pix++;
            end else ovf = 1'b1;
        end
    endtask

    task automatic m_low(input int n);
        int prev;
        prev = run;
        run += n;
        if (prev < LATCH && run >= LATCH) begin
            if (!synced) begin
                synced = 1'b1;
                pix    = 0;
                ovf    = 1'b0;
            end else if (bits != 0) begin
                exp_err++;
                synced = 1'b0;
                bits   = 0;
                run    = 0;
            end else if (pix > 0) begin
                exp_fd++;
                pix = 0;
                ovf = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic v, input int n);
        bus.neopixel_data = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int h, input int l);
        m_high(h);
        drive(1'b1, h);
        m_low(l);
        drive(1'b0, l);
    endtask

    task automatic low(input int n);
        m_low(n);
        drive(1'b0, n);
    endtask

    task automatic send_word(input logic [23:0] w, input bit slow);
        for (int i = 23; i >= 0; i--)
            if (slow) pulse(w[i] ? 35 : 18, w[i] ? 25 : 42);
            else pulse(w[i] ? 32 : 12, 6);
    endtask

    task automatic checkpoint(input string name);
        low(10);
        chk({name, " frame_done count"}, got_fd, exp_fd);
        chk({name, " error count"}, got_err, exp_err);
        chk({name, " overflow"}, {31'd0, bus.overflow}, {31'd0, ovf});
        chk({name, " pixels outstanding"}, expq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_done) got_fd++;
            if (bus.error) got_err++;
            if (bus.pixel_valid && bus.frame_done) begin
                fails++;
                $display("FAIL coincide: pixel_valid and frame_done both high, required never together");
            end
            if (bus.pixel_valid) begin
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL pixel: got idx %0d grb %h, expected no pixel", bus.pixel_index,
                             {bus.green, bus.red, bus.blue});
                end else begin
                    e = expq.pop_front();
                    if ({bus.pixel_index, bus.green, bus.red, bus.blue} !== e) begin
                        fails++;
                        $display("FAIL pixel: got idx %0d grb %h, expected idx %0d grb %h", bus.pixel_index,
                                 {bus.green, bus.red, bus.blue}, e[26:24], e[23:0]);
                    end
                end
                last_pix[bus.pixel_index] = {bus.green, bus.red, bus.blue};
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got no finish within 150000 cycles, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.neopixel_data = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset pixel_valid", {31'd0, bus.pixel_valid}, 0);
        chk("reset outputs", {bus.pixel_index, bus.green, bus.red, bus.blue, bus.frame_done, bus.error, bus.overflow}, 0);
        rst = 1'b0;
        // power-on: a bit after a 2499-cycle gap must be ignored
        drive(1'b1, 100);
        low(2499);
        pulse(35, 25);
        checkpoint("power-on short gap");
        low(2500);
        checkpoint("power-on latch");
        send_word(24'hA5C30F, 1'b0);
        low(2500);
        checkpoint("power-on pixel");
        // single pixel with slow timing, and raw-fall to pixel_valid latency
        for (int i = 23; i >= 1; i--) send_word_bit(24'h12FF00, i);
        m_high(18);
        drive(1'b1, 18);
        m_low(42);
        bus.neopixel_data = 1'b0;
        lat = 0;
        for (int i = 1; i <= 42; i++) begin
            @(negedge clk);
            if (bus.pixel_valid && lat == 0) lat = i;
        end
        chk("latency", lat, 4);
        low(2500);
        checkpoint("single");
        chk("single red", {24'd0, bus.red}, 32'hFF);
        chk("single green", {24'd0, bus.green}, 32'h12);
        chk("single blue", {24'd0, bus.blue}, 32'h00);
        chk("single index", {29'd0, bus.pixel_index}, 0);
        // pulse-width boundaries: 8 and 29 are zeros, 30 and 59 are ones
        for (int i = 23; i >= 0; i--) pulse((23 - i) % 4 == 0 ? 8 : (23 - i) % 4 == 1 ? 29 : (23 - i) % 4 == 2 ? 30 : 59, 6);
        low(2500);
        checkpoint("boundary");
        chk("boundary grb", {8'd0, bus.green, bus.red, bus.blue}, 32'h333333);
        // full frame
        for (int k = 0; k < NP; k++) begin
            kb = 8'(k);
            send_word({8'h80 | kb, kb, ~kb}, 1'b0);
        end
        low(2500);
        checkpoint("full frame");
        chk("full frame last pixel", {8'd0, last_pix[7]}, 32'h8707F8);
        // overflow
        for (int k = 0; k < 10; k++) begin
            kb = 8'(k);
            send_word({kb, 8'h40, ~kb}, 1'b0);
            if (k == 7) chk("overflow after word 8", {31'd0, bus.overflow}, 0);
            if (k == 8) chk("overflow after word 9", {31'd0, bus.overflow}, 1);
        end
        low(2500);
        checkpoint("overflow");
        chk("overflow after latch", {31'd0, bus.overflow}, 0);
        // errors, each from five good bits
        for (int i = 0; i < 5; i++) pulse(32, 6);
        pulse(4, 20);
        low(2600);
        send_word(24'h010203, 1'b0);
        low(2500);
        checkpoint("short pulse");
        for (int i = 0; i < 5; i++) pulse(12, 6);
        pulse(60, 20);
        low(2600);
        send_word(24'h445566, 1'b0);
        low(2500);
        checkpoint("long pulse");
        for (int i = 0; i < 12; i++) pulse(12, 6);
        low(2500);
        low(2600);
        send_word(24'h778899, 1'b0);
        low(2500);
        checkpoint("partial word");
        // reset mid-frame: the next word is ignored until a full latch
        for (int i = 0; i < 10; i++) pulse(32, 6);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        synced = 1'b0;
        bits   = 0;
        run    = 0;
        pix    = 0;
        ovf    = 1'b0;
        send_word(24'hDEAD01, 1'b0);
        low(2600);
        checkpoint("reset ignore");
        send_word(24'hBEEF02, 1'b0);
        low(2500);
        checkpoint("reset recover");
        // loopback frame with pixel 3 white
        for (int k = 0; k < NP; k++) begin
            kb = 8'(k);
            send_word(k == 3 ? 24'hFFFFFF : {kb, kb << 4, 8'h5A ^ kb}, 1'b0);
        end
        low(2500);
        checkpoint("loopback");
        chk("loopback pixel 3", {8'd0, last_pix[3]}, 32'hFFFFFF);
        chk("total frame_done", got_fd, 10);
        chk("total error", got_err, 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic send_word_bit(input logic [23:0] w, input int i);
        pulse(w[i] ? 35 : 18, w[i] ? 25 : 42);
    endtask
endmodule
